// File: rtl/gate_bist_ctrl_if.sv
// Signal bundle between the gate self-test sequencer and whoever starts it / hosts the gate.
// The sequencer uses the slave view; a test harness or gate wrapper uses the master view.
interface gate_bist_ctrl_if;
  logic       start;
  logic       y_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] fail_vec;
  logic       fail_valid;

  modport master (
    output start, y_in,
    input  a_out, b_out, busy, done, pass, err_count, fail_vec, fail_valid
  );

  modport slave (
    input  start, y_in,
    output a_out, b_out, busy, done, pass, err_count, fail_vec, fail_valid
  );
endinterface

// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer for a 2-input gate: walks {a,b}=00..11, waits a settle time,
// then compares the gate output against a truth table and reports a summary.
module gate_bist_ctrl #(
  parameter logic [3:0]  TRUTH         = 4'b0111,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  gate_bist_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] err_q, err_d;
  logic [1:0] fail_vec_q, fail_vec_d;
  logic       fail_valid_q, fail_valid_d;
  logic       pass_q, pass_d;
  logic       mismatch;

  // Case-inequality so an undriven or X gate output counts as a failure.
  assign mismatch = (bus.y_in !== TRUTH[idx_q]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= 4'd0;
      err_q        <= 3'd0;
      fail_vec_q   <= 2'd0;
      fail_valid_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
      pass_q       <= pass_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;
    pass_d       = pass_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d      = APPLY;
          idx_d        = 2'd0;
          err_d        = 3'd0;
          fail_vec_d   = 2'd0;
          fail_valid_d = 1'b0;
          pass_d       = 1'b0;
        end
      end

      APPLY: begin
        cnt_d   = SETTLE_INIT;
        state_d = SETTLE;
      end

      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (mismatch) begin
          err_d = err_q + 3'd1;
          if (!fail_valid_q) begin
            fail_vec_d   = idx_q;
            fail_valid_d = 1'b1;
          end
        end
        // idx stays at 3 after the last vector so the gate inputs hold 11 while idle.
        if (idx_q == 2'd3) begin
          state_d = DONE;
          pass_d  = (err_d == 3'd0);
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = APPLY;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.a_out      = idx_q[1];
  assign bus.b_out      = idx_q[0];
  assign bus.busy       = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
  assign bus.done       = (state_q == DONE);
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_vec   = fail_vec_q;
  assign bus.fail_valid = fail_valid_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: a behavioural gate model feeds y_in, predicted run summaries
// are queued at each start and compared when the done pulse appears.
module tb_gate_bist_ctrl;

  localparam int M_NAND   = 0;
  localparam int M_STUCK1 = 1;
  localparam int M_AND    = 2;
  localparam int M_XON01  = 3;

  localparam logic [3:0] NAND_TABLE = 4'b0111;
  localparam int DONE_CYCLE = 17;

  typedef struct {
    logic [2:0] err;
    logic       fv;
    logic [1:0] vec;
    logic       pass;
  } exp_t;

  logic clk;
  logic reset;
  int   gate_mode;
  int   tests_run;
  int   tests_failed;
  exp_t sb[$];

  gate_bist_ctrl_if bus ();

  gate_bist_ctrl #(
    .TRUTH         (4'b0111),
    .SETTLE_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic gate_model(input int m, input logic a, input logic b);
    case (m)
      M_STUCK1: return 1'b1;
      M_AND:    return a & b;
      M_XON01:  return ({a, b} == 2'b01) ? 1'bx : ~(a & b);
      default:  return ~(a & b);
    endcase
  endfunction

  always_comb bus.y_in = gate_model(gate_mode, bus.a_out, bus.b_out);

  function automatic exp_t predict(input int m);
    exp_t e;
    logic y;
    logic [1:0] v;
    e.err = 3'd0;
    e.fv  = 1'b0;
    e.vec = 2'd0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      y = gate_model(m, v[1], v[0]);
      if (y !== NAND_TABLE[i]) begin
        e.err = e.err + 3'd1;
        if (!e.fv) begin
          e.fv  = 1'b1;
          e.vec = v;
        end
      end
    end
    e.pass = (e.err == 3'd0);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue the predicted summary for this gate behaviour and pulse start for one edge.
  task automatic applyStimulus(input int m, input bit push);
    gate_mode = m;
    if (push) sb.push_back(predict(m));
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic collectResult(input bit repulse, input bit check_vectors);
    int   n;
    int   pulses;
    bit   seen;
    exp_t e;
    n    = 0;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      @(negedge clk);
      n++;
      if (repulse && n == 6) bus.start = 1'b1;
      if (repulse && n == 7) bus.start = 1'b0;
      if (check_vectors && n <= 16) begin
        checkOutput("vector_ab", {6'd0, bus.a_out, bus.b_out}, 8'((n - 1) / 4));
        checkOutput("busy_run", {7'd0, bus.busy}, 8'd1);
      end
      if (bus.done) seen = 1'b1;
    end
    checkOutput("done_seen", {7'd0, seen}, 8'd1);
    if (!seen) return;
    checkOutput("done_cycle", 8'(n), 8'(DONE_CYCLE));
    if (sb.size() == 0) begin
      checkOutput("sb_nonempty", 8'd0, 8'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput("err_count", {5'd0, bus.err_count}, {5'd0, e.err});
    checkOutput("fail_valid", {7'd0, bus.fail_valid}, {7'd0, e.fv});
    checkOutput("fail_vec", {6'd0, bus.fail_vec}, {6'd0, e.vec});
    checkOutput("pass", {7'd0, bus.pass}, {7'd0, e.pass});
    checkOutput("busy_done", {7'd0, bus.busy}, 8'd0);
    @(negedge clk);
    checkOutput("done_pulse", {7'd0, bus.done}, 8'd0);
    checkOutput("pass_held", {7'd0, bus.pass}, {7'd0, e.pass});
    checkOutput("ab_hold", {6'd0, bus.a_out, bus.b_out}, 8'd3);
    if (repulse) begin
      pulses = 1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (bus.done) pulses++;
      end
      checkOutput("done_once", 8'(pulses), 8'd1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_ab"}, {6'd0, bus.a_out, bus.b_out}, 8'd0);
    checkOutput({tag, "_busy"}, {7'd0, bus.busy}, 8'd0);
    checkOutput({tag, "_done"}, {7'd0, bus.done}, 8'd0);
    checkOutput({tag, "_pass"}, {7'd0, bus.pass}, 8'd0);
    checkOutput({tag, "_err"}, {5'd0, bus.err_count}, 8'd0);
    checkOutput({tag, "_fvec"}, {6'd0, bus.fail_vec}, 8'd0);
    checkOutput({tag, "_fvalid"}, {7'd0, bus.fail_valid}, 8'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    gate_mode    = M_NAND;
    bus.start    = 1'b0;
    reset        = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values("por");

    applyStimulus(M_NAND, 1'b1);
    collectResult(1'b0, 1'b1);

    applyStimulus(M_STUCK1, 1'b1);
    collectResult(1'b0, 1'b0);

    applyStimulus(M_AND, 1'b1);
    collectResult(1'b0, 1'b0);

    applyStimulus(M_NAND, 1'b1);
    collectResult(1'b1, 1'b0);

    // Abort mid-run: reset is sampled at the edge ending the CHECK cycle of vector 2.
    applyStimulus(M_STUCK1, 1'b0);
    for (int n = 1; n <= 12; n++) @(negedge clk);
    checkOutput("pre_reset_ab", {6'd0, bus.a_out, bus.b_out}, 8'd2);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values("midrun");
    repeat (20) @(negedge clk);
    checkOutput("no_done_after_reset", {7'd0, bus.done}, 8'd0);

    applyStimulus(M_NAND, 1'b1);
    collectResult(1'b0, 1'b1);

    applyStimulus(M_XON01, 1'b1);
    collectResult(1'b0, 1'b0);

    applyStimulus(M_NAND, 1'b1);
    collectResult(1'b0, 1'b0);

    checkOutput("sb_drained", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
